// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, unsigned or
// two's-complement operands, valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one partial product per cycle, WIDTH cycles total
// DONE  | product held with out_valid high until out_ready
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mcand, mplier;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc, acc_sum, partial;
    logic [CW-1:0]        cnt;
    logic                 sign, last, accept;

    assign accept  = in_valid && in_ready;
    assign last    = (cnt == CW'(WIDTH-1));
    // Magnitude of the most negative value wraps to itself, which read as
    // unsigned is exactly 2^(WIDTH-1).
    assign a_mag   = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign partial = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    assign acc_sum = acc + partial;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        sign   <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        product <= sign ? -acc_sum : acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_shift_add_mult.md
# seq_shift_add_mult

Parametrised sequential shift-add multiplier: multiplies two WIDTH-bit operands, unsigned or two's-complement, over WIDTH clock cycles, returning a 2*WIDTH-bit product. It replaces fixed-size gate-level array multipliers wherever area matters more than latency. Valid/ready handshakes on both the input and output sides let it sit between streaming producers and consumers in the datapath.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = treat a and b as two's complement; 0 = unsigned.
- out_valid  output  1  product valid; held until consumed.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result, two's complement when the captured mode was signed.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid && in_ready, capture a, b and signed_mode.
  - In signed mode, store |a| and |b| (negate if MSB set) and record sign = a[MSB] ^ b[MSB].
  - In unsigned mode, store raw operands and set sign = 0.
  - Clear the accumulator and bit counter, then go to CALC.
- CALC: each cycle, if the LSB of the multiplier register is 1, add the multiplicand (shifted by the counter) into the 2*WIDTH accumulator. Shift the multiplier right and increment the counter.
  - After the cycle that processes bit WIDTH-1, load product = sign ? -acc : acc (2*WIDTH-bit two's complement), assert out_valid, and go to DONE.
- DONE: product and out_valid held stable. On out_ready=1, deassert out_valid and go to IDLE. There is no bypass from DONE straight into CALC.
- Inputs other than out_ready are ignored outside IDLE. Changes to a, b or signed_mode after acceptance have no effect.
- Width rules:
  - The accumulator never overflows 2*WIDTH bits in either mode.
  - Signed (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) is representable.
  - The magnitude of -2^(WIDTH-1) is held in WIDTH bits as unsigned 2^(WIDTH-1).
- Zero operands take the full WIDTH cycles; there is no early termination.

## Timing
- Reset (rst_n=0 at a rising edge) forces state=IDLE, in_ready=1, out_valid=0, product=0, accumulator=0, counter=0. This applies in any state, including mid-CALC or in DONE with out_valid high. The in-flight result is discarded.
- Acceptance edge E0. CALC occupies edges E1..E_WIDTH. out_valid=1 and the final product are visible immediately after E_WIDTH.
  - Latency is WIDTH cycles from acceptance to out_valid.
- With out_ready tied high, out_valid is a single-cycle pulse: DONE→IDLE on edge E_WIDTH+1.
  - The next operand is accepted at E_WIDTH+2 at the earliest.
  - Throughput is one product per WIDTH+2 cycles.
- in_ready is combinational from state only. It never depends on in_valid or out_ready.
- product changes only on the transition into DONE or on reset. It is stable throughout DONE.

## Test plan
- WIDTH=8, unsigned, a=0xFF, b=0xFF -> out_valid 8 cycles after acceptance, product=0xFE01; in_ready low throughout CALC/DONE.
- WIDTH=8, signed: a=0x80, b=0x80 -> product=0x4000. a=0xFD, b=0x05 -> 0xFFF1 (-15). Same a=0xFD, b=0x05 unsigned -> 0x04F1 (1265).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling a/b/in_valid -> product and out_valid stay constant, in_ready stays 0. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Reset mid-operation: assert rst_n=0 for one edge at CALC cycle 3 -> next cycle in_ready=1, out_valid=0, product=0. A subsequent 7*6 unsigned yields 42 with correct latency.
- WIDTH=3, exhaustive: all 64 {a,b} pairs in both modes, out_ready=1, back-to-back in_valid -> every product equals the reference a*b (sign-extended in signed mode). Spacing between results is exactly 5 cycles.
- WIDTH=16 random: 1000 random operand/mode pairs with random out_ready stalls -> all products match the model; no result lost or duplicated.
